// File: rtl/ripple_adder4.sv
// Registered WIDTH-bit ripple-carry adder built from explicit
// full-adder cells; one-cycle latency with a valid tag.

// Single-bit full-adder cell: sum and majority carry.
module ripple_adder4_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module ripple_adder4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    assign w_c[0] = cin;

    // Carry ripples bit 0 upward through one cell per bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        ripple_adder4_fa u_fa (
            .i_a (a[gi]),
            .i_b (b[gi]),
            .i_c (w_c[gi]),
            .o_s (w_s[gi]),
            .o_c (w_c[gi+1])
        );
    end

    // Capture the chain result on valid; reset dominates any valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_s;
                r_cout <= w_c[WIDTH];
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_ripple_adder4.sv
// Scoreboard bench for ripple_adder4: expected totals queued at
// drive time and compared when out_valid reports a result.

module tb_ripple_adder4;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] sum;
    logic       cout;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    logic [4:0] sb_q[$];
    logic [4:0] last_res;

    ripple_adder4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, predict, then check after the edge.
    task automatic cyc(input logic [3:0] ia, input logic [3:0] ib,
                       input logic ic, input logic iv,
                       input logic irst);
        logic       exp_v;
        logic [4:0] e;
        a        = ia;
        b        = ib;
        cin      = ic;
        in_valid = iv;
        rst_n    = irst;
        exp_v    = iv & irst;
        if (exp_v)
            sb_q.push_back(5'(ia) + 5'(ib) + 5'(ic));
        @(posedge clk);
        #1;
        if (!irst) begin
            sb_q.delete();
            last_res = '0;
        end
        chk("valid", 8'(out_valid), 8'(exp_v));
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 8'(1), 8'(0));
            end else begin
                e = sb_q.pop_front();
                chk("result", 8'({cout, sum}), 8'(e));
                last_res = e;
            end
        end else begin
            chk("hold", 8'({cout, sum}), 8'(last_res));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        in_valid = 1'b0;
        last_res = '0;
        @(negedge clk);

        // Reset with valid asserted: nothing may come out.
        cyc(4'd5, 4'd6, 1'b0, 1'b1, 1'b0);
        cyc(4'd5, 4'd6, 1'b0, 1'b1, 1'b0);
        chk("rst_sum", 8'(sum), 8'd0);
        chk("rst_cout", 8'(cout), 8'd0);

        // Basic and carry cases.
        cyc(4'd3, 4'd4, 1'b0, 1'b1, 1'b1);
        chk("basic", 8'({cout, sum}), 8'd7);
        cyc(4'd15, 4'd1, 1'b0, 1'b1, 1'b1);
        chk("wrap", 8'({cout, sum}), 8'h10);
        cyc(4'd15, 4'd15, 1'b1, 1'b1, 1'b1);
        chk("max", 8'({cout, sum}), 8'h1f);
        cyc(4'd15, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("full_wrap", 8'({cout, sum}), 8'h10);

        // Hold: result stays while in_valid is low.
        cyc(4'd9, 4'd2, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'd1, 4'd1, 1'b0, 1'b0, 1'b1);
            chk("hold11", 8'(sum), 8'd11);
        end

        // Exhaustive, back-to-back.
        for (int i = 0; i < 512; i++)
            cyc(4'(i), 4'(i >> 4), 1'(i >> 8), 1'b1, 1'b1);

        // Random at cin=0.
        for (int i = 0; i < 20000; i++)
            cyc(4'($urandom_range(15)), 4'($urandom_range(15)),
                1'b0, 1'b1, 1'b1);

        // Reset mid-stream drops the valid on the reset edge.
        cyc(4'd7, 4'd8, 1'b0, 1'b1, 1'b0);
        chk("mid_rst", 8'({cout, sum}), 8'd0);
        cyc(4'd1, 4'd1, 1'b0, 1'b1, 1'b1);
        chk("post_rst", 8'(sum), 8'd2);

        cyc(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("sb_drained", 8'(sb_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
